display_scan_driver: RTL
========================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot; elaboration SHALL fail if REFRESH_DIV < 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  single-cycle request to display value.
REQ-005 SHALL have port value  input  16  four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-006 SHALL have port dp_in  input  4  decimal-point enables per digit, captured with value.
REQ-007 SHALL have port blank_en  input  1  leading-zero blanking enable, sampled live.
REQ-008 SHALL have port busy  output  1  high while a loaded value awaits its frame boundary.
REQ-009 SHALL have port an  output  4  anode selects, active-low one-hot.
REQ-010 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  output  1  decimal-point cathode, active-low.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is high in the cycle the count equals REFRESH_DIV-1.
REQ-013 A 2-bit digit index SHALL advance 0->1->2->3->0 on each tick, wrapping without a gap.
REQ-014 Frame boundary is a tick with index == 3.
REQ-015 On load, value/dp_in SHALL be captured into a pending register and busy SHALL go high the next cycle.
REQ-016 On a frame boundary with busy high, pending SHALL move to the display register and busy SHALL clear the next cycle; the new value SHALL first appear in slot 0.
REQ-017 A load while busy SHALL overwrite pending (latest wins); busy stays high.
REQ-018 A load in the same cycle as a frame-boundary transfer SHALL display the old pending and keep the new load pending; busy stays high.
REQ-019 The display register SHALL NOT change except at a frame boundary, so no frame mixes two values.
REQ-020 an, seg, dp SHALL be registered, reflecting the index and display register one cycle after an index change.
REQ-021 an SHALL be ~(4'b0001 << index); exactly one bit low outside reset.
REQ-022 seg SHALL decode the selected nibble (hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-023 dp SHALL be ~dp bit of the selected digit.
REQ-024 With blank_en high, digit k (k=3..1) SHALL be blanked (seg=7F; an still driven) when its nibble and all higher nibbles are zero; digit 0 is never blanked; a set dp bit SHALL still light dp on a blanked digit.

Reset
REQ-025 While rst is high: prescaler=0, index=0, display and pending registers=0, busy=0, an=4'hF, seg=7'h7F, dp=1, asynchronously.
REQ-026 Reset mid-operation SHALL discard any pending load; after release, scanning restarts at digit 0 with display register 0 (blanking applies).
REQ-027 First posedge after release SHALL drive an=4'b1110.

Verification (REFRESH_DIV=4)
REQ-028 Reset release, no load, blank_en=0 -> an cycles 1110,1101,1011,0111 every 4 clocks, seg=40 throughout, dp=1, busy=0.
REQ-029 load value=16'h12AF dp_in=4'b0100 in slot 1 -> busy=1 until frame boundary; then slot0 seg=0E, slot1 08, slot2 24 with dp=0, slot3 79.
REQ-030 load 16'h1111 then 16'h2222 before the boundary -> only 2222 ever displayed (seg=24 all slots); 1111 never shown.
REQ-031 load 16'h3333 coincident with boundary while 16'h1111 pending -> next frame shows 1111, following frame 3333; busy high until second boundary.
REQ-032 blank_en=1, display 16'h0050 -> digits 3,2 seg=7F, digit1 seg=12, digit0 seg=40; value 16'h0000 -> only digit0 lit (40).
REQ-033 Assert rst mid-frame with load pending -> outputs immediately an=F seg=7F dp=1 busy=0; after release value 0 shown, pending never appears.

Source files
------------

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   A prescaler divides clk into digit slots. A 2-bit index walks the four
//   digits. Loaded values wait in a pending register and are promoted to the
//   display register only at a frame boundary, so a single frame never shows
//   two different values.
//
// Ports
//   clk      : system clock; all state updates on its rising edge
//   rst      : asynchronous, active-high reset
//   load     : single-cycle request to capture value/dp_in
//   value    : four hex nibbles; [3:0] is digit 0 (rightmost)
//   dp_in    : decimal-point enables per digit, captured with value
//   blank_en : leading-zero blanking enable, sampled live
//   busy     : a loaded value is waiting for the next frame boundary
//   an       : anode selects, active-low one-hot
//   seg      : cathodes {g,f,e,d,c,b,a}, active-low
//   dp       : decimal-point cathode, active-low
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_en,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // A divider below 2 would make every cycle a tick and leave no slot time.
  if (REFRESH_DIV < 2) begin : g_div_check
    $error("display_scan_driver: REFRESH_DIV must be at least 2");
  end

  localparam int             CW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   disp_val_reg;
  logic [3:0]    disp_dp_reg;
  logic [15:0]   pend_val_reg;
  logic [3:0]    pend_dp_reg;
  logic          busy_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;

  logic          tick;
  logic          frame_end;
  logic          promote;
  logic [3:0]    nib_zero;
  logic [3:0]    blank_mask;
  logic [3:0]    cur_nib;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick      = (presc_reg == LAST);
  assign frame_end = tick && (idx_reg == 2'd3);
  assign promote   = frame_end && busy_reg;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is blankable when it and every more significant nibble are zero.
  // Digit 0 always shows so that a zero value still lights one digit.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_nib_zero
    assign nib_zero[gi] = (disp_val_reg[4*gi +: 4] == 4'h0);
  end
  assign blank_mask[3] = nib_zero[3];
  for (gi = 1; gi < 3; gi++) begin : g_blank_chain
    assign blank_mask[gi] = nib_zero[gi] & blank_mask[gi+1];
  end
  assign blank_mask[0] = 1'b0;

  always_comb begin
    cur_nib  = disp_val_reg[{idx_reg, 2'b00} +: 4];
    an_next  = ~(4'b0001 << idx_reg);
    seg_next = (blank_en && blank_mask[idx_reg]) ? 7'h7F : hex7(cur_nib);
    dp_next  = ~disp_dp_reg[idx_reg];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg    <= '0;
      idx_reg      <= 2'd0;
      disp_val_reg <= 16'h0000;
      disp_dp_reg  <= 4'h0;
      pend_val_reg <= 16'h0000;
      pend_dp_reg  <= 4'h0;
      busy_reg     <= 1'b0;
      an_reg       <= 4'hF;
      seg_reg      <= 7'h7F;
      dp_reg       <= 1'b1;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + CW'(1);
      if (tick) begin
        idx_reg <= idx_reg + 2'd1;
      end

      // Promotion reads the old pending contents, so a coincident load is
      // kept for the following frame rather than being skipped.
      if (promote) begin
        disp_val_reg <= pend_val_reg;
        disp_dp_reg  <= pend_dp_reg;
      end

      if (load) begin
        pend_val_reg <= value;
        pend_dp_reg  <= dp_in;
        busy_reg     <= 1'b1;
      end else if (promote) begin
        busy_reg     <= 1'b0;
      end

      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign busy = busy_reg;
  assign an   = an_reg;
  assign seg  = seg_reg;
  assign dp   = dp_reg;

endmodule
